// File: rtl/ysyx_22050598_ifu_fetch_pkg.sv
// Shared IFU constants, state encoding and the held-entry record.
// Pure declarations: no latency, no backpressure.
package ysyx_22050598_ifu_fetch_pkg;

  localparam logic [63:0] RESET_PC = 64'h8000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    IFU_REQ  = 2'd0,
    IFU_WAIT = 2'd1,
    IFU_HOLD = 2'd2
  } ifu_state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        fault;
  } if_entry_t;

  // Instruction fetches are word aligned; the low two bits never reach the bus.
  function automatic logic [63:0] align_pc(input logic [63:0] pc);
    return pc & ~64'd3;
  endfunction

endpackage

// File: rtl/ysyx_22050598_ifu_fetch_if.sv
// Instruction bus between fetch (master) and memory (slave): one request, one response.
// Request completes on valid&ready; response is a single-cycle pulse with no backpressure.
interface ysyx_22050598_ifu_fetch_if;

  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  resp_valid,
    input  resp_data,
    input  resp_err
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output resp_valid,
    output resp_data,
    output resp_err
  );

endinterface

// File: rtl/ysyx_22050598_ifu_pc.sv
// Program counter register: redirect beats advance, advance adds 4 (wraps modulo 2^64).
// Updates one cycle after the request; no backpressure of its own.
module ysyx_22050598_ifu_pc
  import ysyx_22050598_ifu_fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC_P = RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        advance,
  output logic [63:0] pc_q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC_P;
    end else if (redirect_valid) begin
      pc_q <= align_pc(redirect_pc);
    end else if (advance) begin
      pc_q <= pc_q + 64'd4;
    end
  end

endmodule

// File: rtl/ysyx_22050598_ifu_fetch.sv
// Fetch stage: one outstanding word fetch, result held for decode; 3 cycles/inst at zero wait.
// Stalls in HOLD until decode takes the entry; redirects flush held or in-flight fetches.
module ysyx_22050598_ifu_fetch
  import ysyx_22050598_ifu_fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC_P = RESET_PC,
  parameter logic [31:0] NOP_INST_P = NOP_INST
) (
  input  logic                          clk,
  input  logic                          rst_n,
  ysyx_22050598_ifu_fetch_if.master     imem,
  input  logic                          redirect_valid_i,
  input  logic [63:0]                   redirect_pc_i,
  output logic                          if_valid_o,
  input  logic                          id_ready_i,
  output logic [31:0]                   if_inst_o,
  output logic [63:0]                   if_pc_o,
  output logic                          if_fault_o
);

  ifu_state_e  state_q;
  logic        drop_q;
  logic        if_valid_q;
  if_entry_t   entry_q;
  logic [63:0] pc_q;
  logic        capture;

  // A response is kept only if nothing has invalidated it, including a redirect this cycle.
  assign capture = (state_q == IFU_WAIT) && imem.resp_valid && !drop_q && !redirect_valid_i;

  ysyx_22050598_ifu_pc #(
    .RESET_PC_P (RESET_PC_P)
  ) u_pc (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid_i),
    .redirect_pc    (redirect_pc_i),
    .advance        (capture),
    .pc_q           (pc_q)
  );

  assign imem.req_valid = rst_n && (state_q == IFU_REQ);
  assign imem.req_addr  = pc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IFU_REQ;
      drop_q     <= 1'b0;
      if_valid_q <= 1'b0;
      entry_q    <= '0;
    end else begin
      case (state_q)
        IFU_REQ: begin
          if (imem.req_ready) begin
            state_q <= IFU_WAIT;
            drop_q  <= redirect_valid_i;
          end
        end
        IFU_WAIT: begin
          if (imem.resp_valid) begin
            if (capture) begin
              entry_q.pc    <= pc_q;
              entry_q.inst  <= imem.resp_err ? NOP_INST_P : imem.resp_data;
              entry_q.fault <= imem.resp_err;
              if_valid_q    <= 1'b1;
              state_q       <= IFU_HOLD;
            end else begin
              drop_q  <= 1'b0;
              state_q <= IFU_REQ;
            end
          end else if (redirect_valid_i) begin
            drop_q <= 1'b1;
          end
        end
        IFU_HOLD: begin
          if (redirect_valid_i || id_ready_i) begin
            if_valid_q <= 1'b0;
            state_q    <= IFU_REQ;
          end
        end
        default: begin
          state_q <= IFU_REQ;
        end
      endcase
    end
  end

  assign if_valid_o = if_valid_q;
  assign if_inst_o  = entry_q.inst;
  assign if_pc_o    = entry_q.pc;
  assign if_fault_o = entry_q.fault;

endmodule

// File: tb/tb_ysyx_22050598_ifu_fetch.sv
// Directed bench: bus responder checks request addresses, output monitor checks deliveries
// against queues filled by the stimulus process.
module tb_ysyx_22050598_ifu_fetch;
  import ysyx_22050598_ifu_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        if_valid;
  logic        id_ready;
  logic [31:0] if_inst;
  logic [63:0] if_pc;
  logic        if_fault;

  ysyx_22050598_ifu_fetch_if imem ();

  ysyx_22050598_ifu_fetch dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem             (imem),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .if_valid_o       (if_valid),
    .id_ready_i       (id_ready),
    .if_inst_o        (if_inst),
    .if_pc_o          (if_pc),
    .if_fault_o       (if_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        fault;
  } exp_t;

  exp_t        exp_out_q[$];
  logic [63:0] exp_addr_q[$];
  int          checks = 0;
  int          failures = 0;

  bit          hold_ready = 1'b0;
  int          resp_delay = 0;
  logic [63:0] err_addr = 64'h1;
  bit          bus_pend = 1'b0;
  int          bus_cnt = 0;
  logic [63:0] bus_addr = '0;
  logic [5:0]  pulse_seen;
  exp_t        e;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0003;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_out(input logic [63:0] pc, input logic [31:0] inst, input logic fault);
    exp_t x;
    x.pc = pc;
    x.inst = inst;
    x.fault = fault;
    exp_out_q.push_back(x);
  endtask

  // Let exactly one request through, then close the bus again.
  task automatic fetch_one(input logic [63:0] addr);
    exp_addr_q.push_back(addr);
    @(negedge clk);
    hold_ready = 1'b0;
    @(negedge clk);
    hold_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2;
  endtask

  // Memory model; abandons its pending response when reset is asserted.
  initial begin
    imem.req_ready  = 1'b0;
    imem.resp_valid = 1'b0;
    imem.resp_data  = '0;
    imem.resp_err   = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      imem.resp_valid = 1'b0;
      imem.resp_data  = '0;
      imem.resp_err   = 1'b0;
      if (!rst_n) begin
        bus_pend = 1'b0;
      end else if (bus_pend) begin
        if (bus_cnt == 0) begin
          imem.resp_valid = 1'b1;
          imem.resp_data  = mem_word(bus_addr);
          imem.resp_err   = (bus_addr == err_addr);
          bus_pend = 1'b0;
        end else begin
          bus_cnt--;
        end
      end
      imem.req_ready = !hold_ready;
      if (rst_n && imem.req_valid && imem.req_ready) begin
        if (exp_addr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL req_unexpected: got addr %h expected no request at %0t", imem.req_addr, $time);
        end else begin
          chk("req_addr", imem.req_addr, exp_addr_q.pop_front());
        end
        bus_pend = 1'b1;
        bus_cnt  = resp_delay;
        bus_addr = imem.req_addr;
      end
    end
  end

  // Delivery monitor: a handshake coinciding with a redirect is a discard, not a delivery.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n === 1'b1 && if_valid && id_ready && !redirect_valid) begin
        if (exp_out_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_unexpected: got pc %h inst %h expected no delivery at %0t", if_pc, if_inst, $time);
        end else begin
          e = exp_out_q.pop_front();
          chk("out_pc", if_pc, e.pc);
          chk("out_inst", {32'd0, if_inst}, {32'd0, e.inst});
          chk("out_fault", {63'd0, if_fault}, {63'd0, e.fault});
        end
      end
    end
  end

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_req_valid", {63'd0, imem.req_valid}, 64'd0);
    chk("rst_if_valid", {63'd0, if_valid}, 64'd0);
    chk("rst_if_inst", {32'd0, if_inst}, 64'd0);
    chk("rst_if_pc", if_pc, 64'd0);
    chk("rst_if_fault", {63'd0, if_fault}, 64'd0);

    // Zero-wait streaming: two fetches, valid pulses 3 cycles apart.
    exp_addr_q.push_back(64'h8000_0000);
    exp_addr_q.push_back(64'h8000_0004);
    push_out(64'h8000_0000, mem_word(64'h8000_0000), 1'b0);
    push_out(64'h8000_0004, mem_word(64'h8000_0004), 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("first_req_valid", {63'd0, imem.req_valid}, 64'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 5) hold_ready = 1'b1;
      #2;
      pulse_seen[i] = if_valid;
    end
    chk("valid_pulse_pattern", {58'd0, pulse_seen}, 64'b010010);

    // Decode stall in HOLD.
    id_ready = 1'b0;
    fetch_one(64'h8000_0008);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #2;
      chk("stall_valid", {63'd0, if_valid}, 64'd1);
      chk("stall_pc", if_pc, 64'h8000_0008);
      chk("stall_inst", {32'd0, if_inst}, {32'd0, mem_word(64'h8000_0008)});
      chk("stall_no_req", {63'd0, imem.req_valid}, 64'd0);
    end
    push_out(64'h8000_0008, mem_word(64'h8000_0008), 1'b0);
    @(negedge clk);
    id_ready = 1'b1;
    @(negedge clk);
    #2;
    chk("after_stall_addr", imem.req_valid ? imem.req_addr : 64'hDEAD, 64'h8000_000C);

    // Redirect while waiting on a slow response.
    resp_delay = 2;
    exp_addr_q.push_back(64'h8000_000C);
    @(negedge clk);
    hold_ready = 1'b0;
    @(negedge clk);
    hold_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0102;
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #2;
      chk("dropped_valid", {63'd0, if_valid}, 64'd0);
    end
    chk("redirect_addr", imem.req_valid ? imem.req_addr : 64'hDEAD, 64'h8000_0100);
    resp_delay = 0;
    push_out(64'h8000_0100, mem_word(64'h8000_0100), 1'b0);
    fetch_one(64'h8000_0100);

    // Redirect in HOLD together with a decode handshake.
    id_ready = 1'b0;
    fetch_one(64'h8000_0104);
    chk("hold_pc", if_valid ? if_pc : 64'hDEAD, 64'h8000_0104);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0200;
    id_ready       = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    chk("hold_flush_valid", {63'd0, if_valid}, 64'd0);
    chk("hold_flush_addr", imem.req_valid ? imem.req_addr : 64'hDEAD, 64'h8000_0200);
    push_out(64'h8000_0200, mem_word(64'h8000_0200), 1'b0);
    fetch_one(64'h8000_0200);

    // Bus error fetch.
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0010;
    @(negedge clk);
    redirect_valid = 1'b0;
    err_addr = 64'h8000_0010;
    push_out(64'h8000_0010, 32'h0000_0013, 1'b1);
    fetch_one(64'h8000_0010);
    chk("fault_next_addr", imem.req_valid ? imem.req_addr : 64'hDEAD, 64'h8000_0014);
    push_out(64'h8000_0014, mem_word(64'h8000_0014), 1'b0);
    fetch_one(64'h8000_0014);

    // PC wrap at the top of the address space.
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    push_out(64'hFFFF_FFFF_FFFF_FFFC, mem_word(64'hFFFF_FFFF_FFFF_FFFC), 1'b0);
    fetch_one(64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_addr", imem.req_valid ? imem.req_addr : 64'hDEAD, 64'd0);

    // Reset while a request is outstanding.
    resp_delay = 3;
    exp_addr_q.push_back(64'd0);
    @(negedge clk);
    hold_ready = 1'b0;
    @(negedge clk);
    hold_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("midrst_req_valid", {63'd0, imem.req_valid}, 64'd0);
    @(negedge clk);
    #2;
    chk("midrst_if_valid", {63'd0, if_valid}, 64'd0);
    chk("midrst_if_inst", {32'd0, if_inst}, 64'd0);
    chk("midrst_if_pc", if_pc, 64'd0);
    chk("midrst_if_fault", {63'd0, if_fault}, 64'd0);
    resp_delay = 0;
    @(negedge clk);
    rst_n = 1'b1;
    push_out(64'h8000_0000, mem_word(64'h8000_0000), 1'b0);
    fetch_one(64'h8000_0000);

    repeat (4) @(negedge clk);
    #2;
    chk("addr_queue_left", 64'(exp_addr_q.size()), 64'd0);
    chk("out_queue_left", 64'(exp_out_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no end of stimulus expected completion before %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
